// File: rtl/bubble_buffer_loader.sv
// bubble_buffer_loader
// Turns the SPI loader byte stream into single-bit writes on the bubble
// out-buffer write port. Bytes are sent LSB first. Channels are interleaved
// for 2-channel or 4-channel operation, and a zero pad is written ahead of
// page data. Completion is signalled on DONE; starvation or abort sets ERR.
module bubble_buffer_loader #(
    parameter int BOOT_POS  = 1328,
    parameter int PAGE_BASE = 7168,
    parameter int PAGE_PAD  = 3,
    parameter int PAGE_POS  = 584,
    parameter int TIMEOUT   = 4096
) (
    input  logic        MCLK,
    input  logic        RESET,
    input  logic        BITWIDTH4,
    input  logic        START,
    input  logic        MODE,
    input  logic        ABORT,
    input  logic [7:0]  BYTE_DATA,
    input  logic        BYTE_VALID,
    output logic        BYTE_READY,
    output logic        nOUTBUFWRCLKEN,
    output logic [14:0] OUTBUFWRADDR,
    output logic        OUTBUFWRDATA,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR
);

    // A bit index is {position, channel}, so a linear index is the write address.
    localparam logic [14:0] BOOT_LAST_2  = 15'(BOOT_POS * 2 - 1);
    localparam logic [14:0] BOOT_LAST_4  = 15'(BOOT_POS * 4 - 1);
    localparam logic [14:0] PAGE_FIRST_2 = 15'(PAGE_BASE * 2);
    localparam logic [14:0] PAGE_FIRST_4 = 15'(PAGE_BASE * 4);
    localparam logic [14:0] PAGE_LAST_2  = 15'((PAGE_BASE + PAGE_POS) * 2 - 1);
    localparam logic [14:0] PAGE_LAST_4  = 15'((PAGE_BASE + PAGE_POS) * 4 - 1);

    localparam int PAD_W = (PAGE_PAD * 4 > 2) ? $clog2(PAGE_PAD * 4) : 1;
    localparam logic [PAD_W-1:0] PAD_LAST_2 = PAD_W'(PAGE_PAD * 2 - 1);
    localparam logic [PAD_W-1:0] PAD_LAST_4 = PAD_W'(PAGE_PAD * 4 - 1);

    localparam int TMO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PAD,
        S_FETCH,
        S_SHIFT,
        S_FIN
    } state_t;

    state_t state, next_state;

    // Load configuration latched at START.
    logic             mode_q;
    logic             wide_q;

    // Datapath.
    logic [14:0]      bit_idx;
    logic [PAD_W-1:0] pad_cnt;
    logic [7:0]       shift_q;
    logic [3:0]       bits_left;
    logic [TMO_W-1:0] tmo_cnt;

    // Decoded events.
    logic             start_ok;
    logic             abort_hit;
    logic             handshake;
    logic             tmo_hit;
    logic             final_wr;
    logic [14:0]      last_idx;
    logic [PAD_W-1:0] pad_last;

    // Next-cycle values for the registered outputs.
    logic             wr_req;
    logic             wr_bit;
    logic             ready_next;
    logic             busy_next;
    logic             done_next;

    // BYTE_READY is only ever high in FETCH, so it doubles as the FETCH qualifier.
    assign start_ok  = (state == S_IDLE) && START;
    assign abort_hit = (state != S_IDLE) && ABORT;
    assign handshake = BYTE_READY && BYTE_VALID;
    assign tmo_hit   = (state == S_FETCH) && !handshake && (tmo_cnt == TMO_LAST);
    assign last_idx  = mode_q ? (wide_q ? PAGE_LAST_4 : PAGE_LAST_2)
                              : (wide_q ? BOOT_LAST_4 : BOOT_LAST_2);
    assign pad_last  = wide_q ? PAD_LAST_4 : PAD_LAST_2;
    assign final_wr  = (state == S_SHIFT) && (bit_idx == last_idx);

    // State register.
    // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge MCLK or posedge RESET) begin
        if (RESET) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; ABORT overrides every transition out of a busy state.
    always_comb begin
        // NOTE: default assignment first so no path leaves next_state unassigned (no latch).
        next_state = state;
        case (state)
            S_IDLE: begin
                if (START) begin
                    next_state = MODE ? S_PAD : S_FETCH;
                end
            end
            S_PAD: begin
                if (pad_cnt == pad_last) begin
                    next_state = S_FETCH;
                end
            end
            S_FETCH: begin
                if (handshake) begin
                    next_state = S_SHIFT;
                end else if (tmo_hit) begin
                    next_state = S_IDLE;
                end
            end
            S_SHIFT: begin
                if (final_wr) begin
                    next_state = S_FIN;
                end else if (bits_left == 4'd1) begin
                    next_state = S_FETCH;
                end
            end
            S_FIN: begin
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
        if (abort_hit) begin
            next_state = S_IDLE;
        end
    end

    // Output decode: write request for this cycle plus status for the next one.
    always_comb begin
        wr_req     = 1'b0;
        wr_bit     = 1'b0;
        ready_next = (next_state == S_FETCH);
        busy_next  = (next_state == S_PAD) || (next_state == S_FETCH) ||
                     (next_state == S_SHIFT);
        done_next  = (next_state == S_FIN);
        case (state)
            S_PAD: begin
                wr_req = !ABORT;
            end
            S_SHIFT: begin
                wr_req = !ABORT;
                wr_bit = shift_q[0];
            end
            default: begin
                wr_req = 1'b0;
            end
        endcase
    end

    // Registered write port and status outputs.
    always_ff @(posedge MCLK or posedge RESET) begin
        if (RESET) begin
            nOUTBUFWRCLKEN <= 1'b1;
            OUTBUFWRADDR   <= '0;
            OUTBUFWRDATA   <= 1'b0;
            BYTE_READY     <= 1'b0;
            BUSY           <= 1'b0;
            DONE           <= 1'b0;
            ERR            <= 1'b0;
        end else begin
            nOUTBUFWRCLKEN <= !wr_req;
            if (wr_req) begin
                OUTBUFWRADDR <= bit_idx;
                OUTBUFWRDATA <= wr_bit;
            end
            BYTE_READY <= ready_next;
            BUSY       <= busy_next;
            DONE       <= done_next;
            if (start_ok) begin
                ERR <= 1'b0;
            end else if (abort_hit || tmo_hit) begin
                ERR <= 1'b1;
            end
        end
    end

    // Datapath: configuration latch, bit index, pad count, shifter, timeout.
    always_ff @(posedge MCLK or posedge RESET) begin
        if (RESET) begin
            mode_q    <= 1'b0;
            wide_q    <= 1'b0;
            bit_idx   <= '0;
            pad_cnt   <= '0;
            shift_q   <= '0;
            bits_left <= '0;
            tmo_cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (START) begin
                        mode_q  <= MODE;
                        wide_q  <= BITWIDTH4;
                        bit_idx <= MODE ? (BITWIDTH4 ? PAGE_FIRST_4 : PAGE_FIRST_2) : '0;
                        pad_cnt <= '0;
                        tmo_cnt <= '0;
                    end
                end
                S_PAD: begin
                    pad_cnt <= pad_cnt + PAD_W'(1);
                    bit_idx <= bit_idx + 15'd1;
                end
                S_FETCH: begin
                    if (handshake) begin
                        shift_q   <= BYTE_DATA;
                        bits_left <= 4'd8;
                        tmo_cnt   <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                S_SHIFT: begin
                    shift_q   <= shift_q >> 1;
                    bits_left <= bits_left - 4'd1;
                    bit_idx   <= bit_idx + 15'd1;
                end
                default: begin
                    bit_idx <= bit_idx;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bubble_buffer_loader.sv
// Bench for bubble_buffer_loader. Byte streams (fixed patterns or $urandom)
// are fed through a VALID/READY driver; every write-port strobe is captured
// and compared with the buffer image expected from position/channel rules.
module tb_bubble_buffer_loader;

    localparam int BOOT_POS  = 1328;
    localparam int PAGE_BASE = 7168;
    localparam int PAGE_PAD  = 3;
    localparam int PAGE_POS  = 584;
    localparam int TIMEOUT   = 16;

    logic        MCLK = 1'b0;
    logic        RESET;
    logic        BITWIDTH4;
    logic        START;
    logic        MODE;
    logic        ABORT;
    logic [7:0]  BYTE_DATA = 8'h00;
    logic        BYTE_VALID = 1'b0;
    logic        BYTE_READY;
    logic        nOUTBUFWRCLKEN;
    logic [14:0] OUTBUFWRADDR;
    logic        OUTBUFWRDATA;
    logic        BUSY;
    logic        DONE;
    logic        ERR;

    always #5 MCLK = ~MCLK;

    bubble_buffer_loader #(
        .BOOT_POS  (BOOT_POS),
        .PAGE_BASE (PAGE_BASE),
        .PAGE_PAD  (PAGE_PAD),
        .PAGE_POS  (PAGE_POS),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .MCLK           (MCLK),
        .RESET          (RESET),
        .BITWIDTH4      (BITWIDTH4),
        .START          (START),
        .MODE           (MODE),
        .ABORT          (ABORT),
        .BYTE_DATA      (BYTE_DATA),
        .BYTE_VALID     (BYTE_VALID),
        .BYTE_READY     (BYTE_READY),
        .nOUTBUFWRCLKEN (nOUTBUFWRCLKEN),
        .OUTBUFWRADDR   (OUTBUFWRADDR),
        .OUTBUFWRDATA   (OUTBUFWRDATA),
        .BUSY           (BUSY),
        .DONE           (DONE),
        .ERR            (ERR)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input int observed, input int expected);
        checks++;
        if (observed != expected) begin
            errors++;
            $display("FAIL %s observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Byte source and driver state.
    logic [7:0] src [0:1023];
    bit         feed_en = 1'b0;
    bit         stall_en = 1'b0;
    int         sent = 0;
    int         stop_after = 0;
    int         stall_run = 0;
    bit         drv_v;

    // Capture of the write port.
    int cyc = 0;
    int wr_addr_q [$];
    int wr_data_q [$];
    int wr_cyc_q  [$];
    int done_cnt = 0;
    int ready_run = 0;
    int last_ready_run = 0;

    // Expected buffer image.
    int exp_addr_q  [$];
    int exp_data_q  [$];
    int exp_group_q [$];
    int exp_bytes;

    // Driver: inputs change on the falling edge, so READY seen here is what the next rising edge uses.
    initial forever begin
        @(negedge MCLK);
        if (feed_en && sent < stop_after) begin
            drv_v = 1'b1;
            if (stall_en && stall_run < 3 && $urandom_range(0, 3) == 0) drv_v = 1'b0;
            stall_run  = drv_v ? 0 : stall_run + 1;
            BYTE_VALID = drv_v;
            BYTE_DATA  = src[sent];
            if (drv_v && BYTE_READY) sent++;
        end else begin
            BYTE_VALID = 1'b0;
            BYTE_DATA  = 8'($urandom);
        end
    end

    // Monitor: samples outputs on the falling edge.
    initial forever begin
        @(negedge MCLK);
        cyc++;
        if (nOUTBUFWRCLKEN == 1'b0) begin
            wr_addr_q.push_back(int'(OUTBUFWRADDR));
            wr_data_q.push_back(int'(OUTBUFWRDATA));
            wr_cyc_q.push_back(cyc);
        end
        if (DONE) done_cnt++;
        if (BYTE_READY) begin
            ready_run++;
        end else if (ready_run > 0) begin
            last_ready_run = ready_run;
            ready_run = 0;
        end
    end

    // Cycle-bounded watchdog.
    initial begin
        repeat (100000) @(posedge MCLK);
        $display("FAIL watchdog cycle budget exhausted");
        $fatal(1);
    end

    task automatic step();
        @(negedge MCLK);
        #1;
    endtask

    // Expected writes: every (position, channel) in the load window, in order.
    task automatic build_model(input bit mode, input bit w4);
        int w, npos, base, k;
        logic [7:0] b;
        w = w4 ? 4 : 2;
        npos = mode ? PAGE_POS : BOOT_POS;
        base = mode ? PAGE_BASE : 0;
        exp_addr_q.delete();
        exp_data_q.delete();
        exp_group_q.delete();
        exp_bytes = 0;
        for (int p = 0; p < npos; p++) begin
            for (int c = 0; c < w; c++) begin
                exp_addr_q.push_back((base + p) * w + c);
                if (mode && p < PAGE_PAD) begin
                    exp_data_q.push_back(0);
                    exp_group_q.push_back(-1);
                end else begin
                    k = (p - (mode ? PAGE_PAD : 0)) * w + c;
                    b = src[k / 8];
                    exp_data_q.push_back(int'(b[k % 8]));
                    exp_group_q.push_back(k / 8);
                    exp_bytes = k / 8 + 1;
                end
            end
        end
    endtask

    task automatic compare_writes(input int n);
        check("wr_count", wr_addr_q.size(), n);
        for (int i = 0; i < n && i < wr_addr_q.size(); i++) begin
            check($sformatf("wr_addr[%0d]", i), wr_addr_q[i], exp_addr_q[i]);
            check($sformatf("wr_data[%0d]", i), wr_data_q[i], exp_data_q[i]);
            if (i > 0 && exp_group_q[i] == exp_group_q[i-1])
                check($sformatf("wr_gap[%0d]", i), wr_cyc_q[i] - wr_cyc_q[i-1], 1);
        end
    endtask

    task automatic start_load(input bit mode, input bit w4, input int pat,
                              input bit stall, input int stop);
        for (int i = 0; i < 1024; i++) begin
            case (pat)
                0:       src[i] = 8'(i % 76 + 1);
                1:       src[i] = 8'hFF;
                default: src[i] = 8'($urandom);
            endcase
        end
        wr_addr_q.delete();
        wr_data_q.delete();
        wr_cyc_q.delete();
        done_cnt       = 0;
        last_ready_run = 0;
        sent           = 0;
        stop_after     = stop;
        stall_en       = stall;
        stall_run      = 0;
        feed_en        = 1'b1;
        MODE           = mode;
        BITWIDTH4      = w4;
        START          = 1'b1;
        step();
        START     = 1'b0;
        MODE      = 1'($urandom);
        BITWIDTH4 = 1'($urandom);
    endtask

    task automatic wait_end(input int bound, output bit reached);
        reached = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (done_cnt > 0 || ERR) begin
                reached = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic wait_writes(input int n, input int bound, output bit reached);
        reached = 1'b0;
        for (int i = 0; i < bound; i++) begin
            if (wr_addr_q.size() >= n) begin
                reached = 1'b1;
                break;
            end
            step();
        end
    endtask

    task automatic finish_load(input bit mode, input bit w4);
        bit reached;
        build_model(mode, w4);
        wait_end(20000, reached);
        check("end_reached", int'(reached), 1);
        repeat (10) step();
        check("done_pulses", done_cnt, 1);
        check("err_after_load", int'(ERR), 0);
        check("busy_after_load", int'(BUSY), 0);
        check("bytes_accepted", sent, exp_bytes);
        compare_writes(exp_addr_q.size());
    endtask

    initial begin
        bit reached;
        RESET     = 1'b1;
        START     = 1'b0;
        MODE      = 1'b0;
        BITWIDTH4 = 1'b0;
        ABORT     = 1'b0;
        repeat (3) step();
        check("rst_wrclken", int'(nOUTBUFWRCLKEN), 1);
        check("rst_addr", int'(OUTBUFWRADDR), 0);
        check("rst_data", int'(OUTBUFWRDATA), 0);
        check("rst_ready", int'(BYTE_READY), 0);
        check("rst_busy", int'(BUSY), 0);
        check("rst_done", int'(DONE), 0);
        check("rst_err", int'(ERR), 0);
        RESET = 1'b0;
        repeat (2) step();

        // Boot, 2-channel, incrementing pattern, VALID always high.
        start_load(1'b0, 1'b0, 0, 1'b0, 1000);
        check("busy_after_start", int'(BUSY), 1);
        finish_load(1'b0, 1'b0);

        // Page, 2-channel, all ones: pad zeros then ones up to 15503.
        start_load(1'b1, 1'b0, 1, 1'b0, 1000);
        finish_load(1'b1, 1'b0);

        // Page, 4-channel, random bytes with stalls, START pulsed while busy.
        start_load(1'b1, 1'b1, 2, 1'b1, 1000);
        wait_writes(300, 5000, reached);
        check("glitch_point_reached", int'(reached), 1);
        MODE      = 1'b0;
        BITWIDTH4 = 1'b0;
        START     = 1'b1;
        step();
        START = 1'b0;
        finish_load(1'b1, 1'b1);

        // Starvation after 10 bytes.
        start_load(1'b0, 1'b0, 2, 1'b0, 10);
        build_model(1'b0, 1'b0);
        wait_end(2000, reached);
        check("starve_end_reached", int'(reached), 1);
        check("starve_err", int'(ERR), 1);
        check("starve_busy", int'(BUSY), 0);
        check("starve_fetch_cycles", last_ready_run, TIMEOUT);
        repeat (20) step();
        check("starve_done", done_cnt, 0);
        check("starve_bytes", sent, 10);
        compare_writes(80);

        // Abort at byte 5 bit 3, then a clean restart.
        start_load(1'b0, 1'b0, 2, 1'b1, 1000);
        check("start_clears_err", int'(ERR), 0);
        build_model(1'b0, 1'b0);
        wait_writes(36, 2000, reached);
        check("abort_point_reached", int'(reached), 1);
        ABORT = 1'b1;
        step();
        ABORT = 1'b0;
        check("abort_wrclken", int'(nOUTBUFWRCLKEN), 1);
        check("abort_err", int'(ERR), 1);
        check("abort_busy", int'(BUSY), 0);
        repeat (20) step();
        check("abort_done", done_cnt, 0);
        compare_writes(36);
        start_load(1'b0, 1'b1, 2, 1'b1, 1000);
        check("restart_err_cleared", int'(ERR), 0);
        finish_load(1'b0, 1'b1);

        // Asynchronous reset in the middle of a page load, then a normal load.
        start_load(1'b1, 1'b1, 2, 1'b1, 1000);
        wait_writes(500, 5000, reached);
        check("reset_point_reached", int'(reached), 1);
        @(negedge MCLK);
        #2;
        RESET = 1'b1;
        #1;
        check("midrst_wrclken", int'(nOUTBUFWRCLKEN), 1);
        check("midrst_busy", int'(BUSY), 0);
        check("midrst_ready", int'(BYTE_READY), 0);
        check("midrst_addr", int'(OUTBUFWRADDR), 0);
        check("midrst_err", int'(ERR), 0);
        repeat (2) step();
        RESET = 1'b0;
        step();
        start_load(1'b1, 1'b0, 2, 1'b1, 1000);
        finish_load(1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bubble_buffer_loader.md
Name: bubble_buffer_loader

Overview:
- Sequencer that fills the bubble out-buffer write port from a byte stream supplied by the SPI loader.
- It serialises bytes LSB-first into single-bit writes, generates the write strobe, address and data, and handles channel interleave for 2-bit and 4-bit modes.
- It inserts the 3-position page pad, and reports completion or starvation.
- Sits between the SPI loader and the out-buffer write interface (nOUTBUFWRCLKEN / OUTBUFWRADDR / OUTBUFWRDATA).

Parameters:
BOOT_POS, 1328, bootloader length in buffer positions (one position = one bit per channel)
PAGE_BASE, 7168, buffer position of first page location
PAGE_PAD, 3, zero positions written before page data
PAGE_POS, 584, total page positions including pad
TIMEOUT, 4096, MCLK cycles allowed waiting for a byte before error

Ports:
MCLK  in  1  48 MHz clock
RESET  in  1  asynchronous, active-high reset
BITWIDTH4  in  1  0 = 2-channel, 1 = 4-channel; sampled at START
START  in  1  one-cycle load request; ignored unless IDLE
MODE  in  1  0 = bootloader load, 1 = user page load; sampled at START
ABORT  in  1  synchronous abort
BYTE_DATA  in  8  byte from SPI loader
BYTE_VALID  in  1  byte available
BYTE_READY  out  1  byte accepted this cycle when VALID&READY
nOUTBUFWRCLKEN  out  1  active-low write strobe, one cycle per bit
OUTBUFWRADDR  out  15  write address {position, channel}
OUTBUFWRDATA  out  1  write bit
BUSY  out  1  load in progress
DONE  out  1  one-cycle pulse on normal completion
ERR  out  1  sticky starvation/abort flag; cleared at next accepted START

Behaviour:
- Reset values:
  - nOUTBUFWRCLKEN=1, OUTBUFWRADDR=0, OUTBUFWRDATA=0.
  - BYTE_READY=0, BUSY=0, DONE=0, ERR=0.
  - State IDLE.
- Width: W = 2 (BITWIDTH4=0) or 4 (BITWIDTH4=1); shift S = 1 or 2.
- Address: OUTBUFWRADDR = (position << S) + channel.
  - 2-bit mode: bit 14 = 0.
  - Channel order within a position: 0..W-1 (even channel first).
- Bit counter: linear index b.
  - Boot: starts at 0 and ends at BOOT_POS*W-1 (2655 / 5311).
  - Page: starts at PAGE_BASE<<S (14336 / 28672) and ends at ((PAGE_BASE+PAGE_POS)<<S)-1 (15503 / 31007).
- States:
  - IDLE: on START, latch MODE and BITWIDTH4, clear ERR, set BUSY. Go to PAD if MODE=1, else FETCH.
  - PAD: emit PAGE_PAD*W writes of data 0, one per cycle (6 or 12). Then go to FETCH.
  - FETCH: assert BYTE_READY. On VALID&READY, load the shift register, set bit count 8, go to SHIFT. Timeout counter increments each cycle without a byte.
  - SHIFT: one write per cycle with data = shift[0], then shift right and increment the address. When 8 bits are done, go to FETCH. When the final address is written, go to FIN; remaining bits of the last byte are discarded.
  - FIN: one cycle with DONE=1, BUSY=0, then IDLE.
- Strobe timing: nOUTBUFWRCLKEN, address and data are registered. The strobe is low in exactly the cycle the address/data are valid, with no gaps within a byte.
- BYTE_READY is registered/asserted only in FETCH; at most one byte is accepted per FETCH visit.
- Timeout: counter reaches TIMEOUT-1 in FETCH → ERR=1, BUSY=0, state IDLE, no DONE. The counter resets on each accepted byte.
- ABORT: in any non-IDLE state → next cycle IDLE, strobe high, ERR=1, no DONE. In IDLE it has no effect.
- Simultaneity:
  - ABORT with START in IDLE: START wins.
  - ABORT with a byte handshake: the byte is consumed, no further writes.
- START while BUSY: ignored, with no effect on the counters.
- Byte count consumed:
  - Boot: 332 (2-bit) / 664 (4-bit).
  - Page: ceil(581*W/8) = 146 / 291.
- Reset mid-load: all outputs return to reset values immediately (async). Partially written buffer contents are left as is.

Test Plan:
- Boot, 2-bit, VALID held high, bytes 0x01..0x4C repeating:
  - First write has addr 0, data 1, followed by seven zeros.
  - Exactly 2656 strobes with contiguous addresses 0..2655.
  - 332 bytes accepted; DONE pulses once; ERR=0.
- Page, 2-bit, bytes 0xFF:
  - Addresses 14336..14341 are written with 0.
  - Addresses 14342..15503 are written with 1.
  - 146 bytes accepted; the last byte's upper 6 bits produce no write.
- Page, 4-bit:
  - Pad covers addresses 28672..28683.
  - Last write is at address 31007 with bit 14 = 1.
  - 291 bytes accepted.
- Starvation: boot load, stop VALID after 10 bytes, with TIMEOUT=16 → ERR=1 and BUSY=0 16 cycles later, no DONE, no further strobes.
- ABORT mid-SHIFT at byte 5 bit 3 → strobe high next cycle, ERR=1. A following START clears ERR and restarts at address 0.
- START pulsed during BUSY and async RESET mid-page → START has no effect. On RESET, nOUTBUFWRCLKEN=1 and BUSY=0 in the same cycle, and the next START works normally.
